// File: rtl/dly_seq_pkg.sv
// Shared encodings for the byte-lane delay sequencer: command ops, directions,
// FSM state codes and lane bit indices.
package dly_seq_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [OP_W-1:0] {
    SET_ONE   = 2'd0,
    SET_ALL   = 2'd1,
    APPLY     = 2'd2,
    SET_APPLY = 2'd3
  } op_e;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] S_SET    = 3'd1;
  localparam logic [ST_W-1:0] S_HOLD   = 3'd2;
  localparam logic [ST_W-1:0] S_LD     = 3'd3;
  localparam logic [ST_W-1:0] S_SETTLE = 3'd4;

  localparam int unsigned DQ0     = 0;
  localparam int unsigned DM_BIT  = 8;
  localparam int unsigned DQS_BIT = 9;

  // True when a bit index addresses a real delay channel of the lane.
  function automatic logic bit_legal(input logic [BIT_W-1:0] b, input int unsigned num_bits);
    return 32'(b) < num_bits;
  endfunction

endpackage

// File: rtl/byte_lane_dly_sequencer_if.sv
// Delay command handshake between calibration control and the lane sequencer.
interface byte_lane_dly_sequencer_if
  import dly_seq_pkg::*;
#(
  parameter int unsigned DLY_WIDTH = 8
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OP_W-1:0]      cmd_op;
  logic                 cmd_dir;
  logic [BIT_W-1:0]     cmd_bit;
  logic [DLY_WIDTH-1:0] cmd_delay;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_bit, cmd_delay,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_bit, cmd_delay,
    output cmd_ready
  );

endinterface

// File: rtl/dly_shadow_regs.sv
// Staged/active shadow copies of every lane delay, mirroring what the I/O cells
// hold, plus the registered readback port.
module dly_shadow_regs
  import dly_seq_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 10,
  parameter int unsigned DLY_WIDTH = 8
) (
  input  logic                 clk_div,
  input  logic                 rst_n,
  input  logic [DLY_WIDTH-1:0] dly_data,
  input  logic [NUM_BITS-1:0]  set_odelay,
  input  logic [NUM_BITS-1:0]  set_idelay,
  input  logic [NUM_BITS-1:0]  ld_odelay,
  input  logic [NUM_BITS-1:0]  ld_idelay,
  input  logic                 rd_dir,
  input  logic [BIT_W-1:0]     rd_bit,
  output logic [DLY_WIDTH-1:0] rd_data
);

  logic [DLY_WIDTH-1:0] staged [2][NUM_BITS];
  logic [DLY_WIDTH-1:0] active [2][NUM_BITS];

  // Set strobes capture the bus into staged; load strobes copy staged to active.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NUM_BITS; b++) begin
        staged[DIR_OUT][b] <= '0;
        staged[DIR_IN][b]  <= '0;
        active[DIR_OUT][b] <= '0;
        active[DIR_IN][b]  <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NUM_BITS; b++) begin
        if (set_odelay[b]) staged[DIR_OUT][b] <= dly_data;
        if (set_idelay[b]) staged[DIR_IN][b]  <= dly_data;
        if (ld_odelay[b])  active[DIR_OUT][b] <= staged[DIR_OUT][b];
        if (ld_idelay[b])  active[DIR_IN][b]  <= staged[DIR_IN][b];
      end
    end
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (bit_legal(rd_bit, NUM_BITS)) begin
      rd_data <= active[rd_dir][rd_bit];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/byte_lane_dly_sequencer.sv
// Sequences set/load delay programming for one DDR3 byte lane (8 DQ, DM, DQS)
// from a valid/ready command stream.
module byte_lane_dly_sequencer
  import dly_seq_pkg::*;
#(
  parameter int unsigned NUM_BITS      = 10,
  parameter int unsigned DLY_WIDTH     = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk_div,
  input  logic                 rst_n,
  byte_lane_dly_sequencer_if.slave cmd,
  output logic [DLY_WIDTH-1:0] dly_data,
  output logic [NUM_BITS-1:0]  set_odelay,
  output logic [NUM_BITS-1:0]  set_idelay,
  output logic [NUM_BITS-1:0]  ld_odelay,
  output logic [NUM_BITS-1:0]  ld_idelay,
  output logic                 err,
  input  logic                 err_clr,
  input  logic                 rd_dir,
  input  logic [BIT_W-1:0]     rd_bit,
  output logic [DLY_WIDTH-1:0] rd_data
);

  localparam logic [NUM_BITS-1:0] ALL_MASK = {NUM_BITS{1'b1}};

  logic [ST_W-1:0]     state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  op_e                 op_q;
  logic                dir_q;
  logic                accept_c;
  logic                err_hit;
  logic [NUM_BITS-1:0] sel_mask;
  logic [NUM_BITS-1:0] set_o_next, set_i_next, ld_o_next, ld_i_next;

  // Next-state and next-strobe decode; strobes are registered so they line up
  // with the state they belong to.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    set_o_next = '0;
    set_i_next = '0;
    ld_o_next  = '0;
    ld_i_next  = '0;
    err_hit    = 1'b0;
    accept_c   = cmd.cmd_valid && cmd.cmd_ready;
    sel_mask   = NUM_BITS'(1) << cmd.cmd_bit;

    case (state)
      S_IDLE: begin
        if (accept_c) begin
          case (op_e'(cmd.cmd_op))
            SET_ONE, SET_APPLY: begin
              if (bit_legal(cmd.cmd_bit, NUM_BITS)) begin
                state_next = S_SET;
                if (cmd.cmd_dir == DIR_IN) set_i_next = sel_mask;
                else                       set_o_next = sel_mask;
              end else begin
                err_hit = 1'b1;
              end
            end
            SET_ALL: begin
              state_next = S_SET;
              if (cmd.cmd_dir == DIR_IN) set_i_next = ALL_MASK;
              else                       set_o_next = ALL_MASK;
            end
            APPLY: begin
              state_next = S_LD;
              if (cmd.cmd_dir == DIR_IN) ld_i_next = ALL_MASK;
              else                       ld_o_next = ALL_MASK;
            end
          endcase
        end
      end
      S_SET: state_next = S_HOLD;
      S_HOLD: begin
        if (op_q == SET_APPLY) begin
          state_next = S_LD;
          if (dir_q == DIR_IN) ld_i_next = ALL_MASK;
          else                 ld_o_next = ALL_MASK;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LD: begin
        if (SETTLE_CYCLES == 0) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_SETTLE;
          cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (cnt == '0) state_next = S_IDLE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register together with every registered output it drives.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cmd.cmd_ready <= 1'b1;
      set_odelay    <= '0;
      set_idelay    <= '0;
      ld_odelay     <= '0;
      ld_idelay     <= '0;
      dly_data      <= '0;
      op_q          <= SET_ONE;
      dir_q         <= DIR_OUT;
      err           <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      cmd.cmd_ready <= (state_next == S_IDLE);
      set_odelay    <= set_o_next;
      set_idelay    <= set_i_next;
      ld_odelay     <= ld_o_next;
      ld_idelay     <= ld_i_next;
      if (accept_c) begin
        op_q  <= op_e'(cmd.cmd_op);
        dir_q <= cmd.cmd_dir;
      end
      if (state == S_IDLE && state_next == S_SET) dly_data <= cmd.cmd_delay;
      if (err_hit)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  dly_shadow_regs #(
    .NUM_BITS  (NUM_BITS),
    .DLY_WIDTH (DLY_WIDTH)
  ) u_shadow (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .dly_data   (dly_data),
    .set_odelay (set_odelay),
    .set_idelay (set_idelay),
    .ld_odelay  (ld_odelay),
    .ld_idelay  (ld_idelay),
    .rd_dir     (rd_dir),
    .rd_bit     (rd_bit),
    .rd_data    (rd_data)
  );

endmodule

// File: tb/tb_byte_lane_dly_sequencer.sv
// Scoreboard bench for byte_lane_dly_sequencer: directed lane scenarios plus
// randomized command streams against a shadow-array reference model.
module tb_byte_lane_dly_sequencer;
  import dly_seq_pkg::*;

  localparam int unsigned NB = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned SC = 4;

  logic          clk_div = 1'b0;
  logic          rst_n   = 1'b0;
  logic          err_clr = 1'b0;
  logic          rd_dir  = 1'b0;
  logic [3:0]    rd_bit  = '0;
  logic [DW-1:0] dly_data, rd_data;
  logic [NB-1:0] set_odelay, set_idelay, ld_odelay, ld_idelay;
  logic          err;

  byte_lane_dly_sequencer_if #(.DLY_WIDTH(DW)) bus ();

  byte_lane_dly_sequencer #(
    .NUM_BITS(NB), .DLY_WIDTH(DW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .cmd        (bus),
    .dly_data   (dly_data),
    .set_odelay (set_odelay),
    .set_idelay (set_idelay),
    .ld_odelay  (ld_odelay),
    .ld_idelay  (ld_idelay),
    .err        (err),
    .err_clr    (err_clr),
    .rd_dir     (rd_dir),
    .rd_bit     (rd_bit),
    .rd_data    (rd_data)
  );

  always #5 clk_div = ~clk_div;

  int unsigned cyc = 0;
  always @(posedge clk_div) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [NB-1:0] so;
    logic [NB-1:0] si;
    logic [NB-1:0] lo;
    logic [NB-1:0] li;
    logic [DW-1:0] d;
  } ev_t;

  ev_t           evq[$];
  int unsigned   evc[$];
  logic [DW-1:0] rdq[$];

  logic [DW-1:0] staged_m [2][NB];
  logic [DW-1:0] active_m [2][NB];
  logic [DW-1:0] dly_m;
  logic          err_m;

  logic rd_req  = 1'b0;
  logic rd_seen = 1'b0;
  always @(posedge clk_div) rd_seen <= rd_req;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NB; b++) begin
        staged_m[d][b] = '0;
        active_m[d][b] = '0;
      end
    dly_m = '0;
    err_m = 1'b0;
  endtask

  // Monitor: every nonzero strobe cycle must match the oldest expected event.
  always @(negedge clk_div) begin
    ev_t got, e;
    int unsigned ec;
    logic [DW-1:0] er;
    got = {set_odelay, set_idelay, ld_odelay, ld_idelay, dly_data};
    if ((set_odelay | set_idelay | ld_odelay | ld_idelay) != '0) begin
      if (evq.size() == 0) begin
        chk("strobe_unexpected", 64'(got), 64'd0);
      end else begin
        e  = evq.pop_front();
        ec = evc.pop_front();
        chk("strobe_event", 64'(got), 64'(e));
        chk("strobe_cycle", 64'(cyc), 64'(ec));
      end
    end
    if (rd_seen && rdq.size() != 0) begin
      er = rdq.pop_front();
      chk("rd_data", 64'(rd_data), 64'(er));
    end
  end

  task automatic push_ev(input logic [NB-1:0] so, input logic [NB-1:0] si,
                         input logic [NB-1:0] lo, input logic [NB-1:0] li,
                         input logic [DW-1:0] d, input int unsigned c);
    evq.push_back({so, si, lo, li, d});
    evc.push_back(c);
  endtask

  task automatic copy_active(input logic dir);
    for (int b = 0; b < NB; b++) active_m[dir][b] = staged_m[dir][b];
  endtask

  // Issue one command, predict its strobes/shadow effects, check err and ready latency.
  task automatic do_cmd(input logic [1:0] op, input logic dir, input logic [3:0] b,
                        input logic [DW-1:0] d, input logic clr);
    int n;
    int exp_lat;
    logic legal;
    logic [NB-1:0] one, all, z;
    int unsigned c;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk_div);
      n++;
    end
    chk("ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    all   = '1;
    z     = '0;
    one   = NB'(1) << b;
    legal = !((op == SET_ONE || op == SET_APPLY) && b >= NB);
    c     = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dir   = dir;
    bus.cmd_bit   = b;
    bus.cmd_delay = d;
    err_clr       = clr;
    exp_lat       = 1;
    if (!legal) begin
      err_m = 1'b1;
    end else begin
      if (clr) err_m = 1'b0;
      case (op)
        SET_ONE: begin
          staged_m[dir][b] = d;
          dly_m = d;
          push_ev(dir ? z : one, dir ? one : z, z, z, d, c + 1);
          exp_lat = 3;
        end
        SET_ALL: begin
          for (int k = 0; k < NB; k++) staged_m[dir][k] = d;
          dly_m = d;
          push_ev(dir ? z : all, dir ? all : z, z, z, d, c + 1);
          exp_lat = 3;
        end
        APPLY: begin
          copy_active(dir);
          push_ev(z, z, dir ? z : all, dir ? all : z, dly_m, c + 1);
          exp_lat = 2 + SC;
        end
        default: begin
          staged_m[dir][b] = d;
          dly_m = d;
          push_ev(dir ? z : one, dir ? one : z, z, z, d, c + 1);
          copy_active(dir);
          push_ev(z, z, dir ? z : all, dir ? all : z, d, c + 3);
          exp_lat = 4 + SC;
        end
      endcase
    end
    @(negedge clk_div);
    bus.cmd_valid = 1'b0;
    err_clr       = 1'b0;
    chk("err_after_cmd", 64'(err), 64'(err_m));
    n = 1;
    while (bus.cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clk_div);
      n++;
    end
    chk("ready_latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic rd_chk(input logic dir, input logic [3:0] b);
    logic [DW-1:0] e;
    e = '0;
    if (b < NB) e = active_m[dir][b];
    rd_dir = dir;
    rd_bit = b;
    rd_req = 1'b1;
    rdq.push_back(e);
    @(negedge clk_div);
    rd_req = 1'b0;
  endtask

  task automatic rd_sweep();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 12; b++) rd_chk(d[0], 4'(b));
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk_div);
    err_clr = 1'b0;
    err_m   = 1'b0;
    chk("err_after_clr", 64'(err), 64'(err_m));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    logic [NB-1:0] all, z;
    all = '1;
    z   = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_bit   = '0;
    bus.cmd_delay = '0;
    model_reset();

    repeat (3) @(negedge clk_div);
    rst_n = 1'b1;
    @(negedge clk_div);
    chk("reset_ready", 64'(bus.cmd_ready), 64'd1);
    chk("reset_strobes", 64'({set_odelay, set_idelay, ld_odelay, ld_idelay}), 64'd0);
    chk("reset_dly_data", 64'(dly_data), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    rd_sweep();

    // Lane scenarios
    do_cmd(SET_ONE, DIR_OUT, 4'd3, 8'h5A, 1'b0);
    rd_chk(DIR_OUT, 4'd3);
    do_cmd(SET_APPLY, DIR_IN, 4'(DQS_BIT), 8'h21, 1'b0);
    rd_chk(DIR_IN, 4'(DQS_BIT));
    rd_chk(DIR_OUT, 4'(DQS_BIT));
    do_cmd(SET_ALL, DIR_OUT, 4'd0, 8'h10, 1'b0);
    do_cmd(APPLY, DIR_OUT, 4'd0, 8'h00, 1'b0);
    rd_sweep();
    do_cmd(SET_ONE, DIR_OUT, 4'd12, 8'hEE, 1'b0);
    clr_err();
    do_cmd(SET_APPLY, DIR_IN, 4'd10, 8'hCC, 1'b1);
    clr_err();
    do_cmd(APPLY, DIR_IN, 4'd0, 8'h00, 1'b0);
    rd_chk(DIR_IN, 4'(DM_BIT));

    // Randomized command stream
    for (int i = 0; i < 80; i++) begin
      do_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
             8'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 1) == 1)
        rd_chk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)));
    end
    rd_sweep();

    // Reset while settling after an APPLY
    do_cmd(SET_ALL, DIR_IN, 4'd0, 8'h77, 1'b0);
    c = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = APPLY;
    bus.cmd_dir   = DIR_IN;
    copy_active(DIR_IN);
    push_ev(z, z, z, all, dly_m, c + 1);
    @(negedge clk_div);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk_div);
    rst_n = 1'b0;
    #1;
    chk("rst_strobes", 64'({set_odelay, set_idelay, ld_odelay, ld_idelay}), 64'd0);
    chk("rst_dly_data", 64'(dly_data), 64'd0);
    model_reset();
    repeat (2) @(negedge clk_div);
    rst_n = 1'b1;
    @(negedge clk_div);
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    rd_sweep();
    do_cmd(SET_APPLY, DIR_OUT, 4'(DQ0), 8'h3C, 1'b0);
    rd_chk(DIR_OUT, 4'(DQ0));
    rd_chk(DIR_IN, 4'(DQ0));

    repeat (3) @(negedge clk_div);
    chk("events_pending", 64'(evq.size()), 64'd0);
    chk("reads_pending", 64'(rdq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_lane_dly_sequencer.md
# byte_lane_dly_sequencer

Sequences delay programming for one DDR3 byte lane: 8 DQ bits, DM and DQS, each with an input and an output fine delay. It accepts delay commands from the calibration/control logic over a valid/ready handshake. It drives the shared 8-bit delay bus plus per-bit set/load strobes into the lane's I/O cells, keeping staged and active shadow copies for readback. It sits directly upstream of the per-bit DQ/DM/DQS I/O cells, in the `clk_div` domain.

## Interface
- `NUM_BITS`, 10: delay channels per direction; bits 0-7 are DQ, 8 is DM, 9 is DQS.
- `DLY_WIDTH`, 8: delay value width; the 3 LSBs are the fine delay.
- `SETTLE_CYCLES`, 4: idle cycles after every load pulse before the next command is accepted; range 0-15.

Ports:
- `clk_div`  in  1  half-rate system clock; all logic is synchronous to it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  2  0 SET_ONE, 1 SET_ALL, 2 APPLY, 3 SET_APPLY.
- `cmd_dir`  in  1  0 = output delay, 1 = input delay.
- `cmd_bit`  in  4  target bit index; used by SET_ONE and SET_APPLY.
- `cmd_delay`  in  DLY_WIDTH  delay value.
- `dly_data`  out  DLY_WIDTH  shared delay bus to all I/O cells.
- `set_odelay`, `set_idelay`  out  NUM_BITS  per-bit stage strobes.
- `ld_odelay`, `ld_idelay`  out  NUM_BITS  per-bit load strobes.
- `err`  out  1  sticky flag for an illegal bit index.
- `err_clr`  in  1  clears `err`.
- `rd_dir`, `rd_bit`  in  1, 4  readback address.
- `rd_data`  out  DLY_WIDTH  active value at the readback address, registered.

## Operation
- FSM states: IDLE, SET, HOLD, LD, SETTLE.
- A command is accepted on the cycle where `cmd_valid && cmd_ready`. The command fields are latched on acceptance.
- SET_ONE, SET_ALL, SET_APPLY: IDLE -> SET.
  - In SET, `dly_data` is driven with the latched delay and the selected set strobe(s) are high for exactly one cycle.
  - SET_ALL asserts all NUM_BITS strobes of the chosen direction.
  - In the same cycle the staged shadow register(s) `[dir][bit]` take the value.
- SET -> HOLD for one cycle (data stability guard). From HOLD:
  - SET_APPLY goes to LD.
  - SET_ONE and SET_ALL go to IDLE.
- APPLY: IDLE -> LD directly.
- In LD, all NUM_BITS load strobes of the chosen direction pulse for one cycle, and the active shadows copy the staged shadows for that direction.
- LD -> SETTLE. A counter counts SETTLE_CYCLES; when it reaches 0 the FSM returns to IDLE. SETTLE_CYCLES = 0 skips SETTLE entirely.
- Illegal index (`cmd_bit` >= NUM_BITS on SET_ONE or SET_APPLY):
  - The command is still accepted, `err` is set, and no strobe is issued.
  - The FSM returns IDLE -> IDLE, so `cmd_ready` stays high.
- `err_clr` clears `err`. If a new error and `err_clr` occur in the same cycle, set wins.
- `dly_data` keeps its last value between commands.
- Readback: `rd_data` presents the active shadow at `[rd_dir][rd_bit]` one cycle after the address. An out-of-range `rd_bit` reads 0.

## Timing
- Reset values: FSM in IDLE, `cmd_ready` 1, all strobes 0, `dly_data` 0, `err` 0, `rd_data` 0, all shadows 0 (matches the I/O cells' reset delay of 0).
- Command accepted at cycle N:
  - SET_ONE / SET_ALL: set strobe at N+1, `cmd_ready` back high at N+3.
  - SET_APPLY: set strobe at N+1, ld strobe at N+3, `cmd_ready` back high at N+4+SETTLE_CYCLES.
  - APPLY: ld strobe at N+1, `cmd_ready` back high at N+2+SETTLE_CYCLES.
- Set and ld strobes never overlap, and strobes never fire for both directions in the same cycle.
- Asserting `rst_n` low mid-command drops all strobes immediately and discards the command; staged and active shadows reset to 0.

## Structure
- Package `dly_seq_pkg` holds:
  - op encodings SET_ONE, SET_ALL, APPLY, SET_APPLY;
  - direction encodings DIR_OUT, DIR_IN;
  - the FSM state enumeration;
  - bit-index constants DQ0, DM_BIT = 8, DQS_BIT = 9.
- One sub-module, `dly_shadow_regs`, holds the 2 x NUM_BITS staged and active register banks, the stage write, the bulk copy on ld, and the registered readback mux.
- The FSM and settle counter live in the top module.

## Test plan
- Post reset: `cmd_ready`=1, all strobes 0, `rd_data` 0 for every address.
- SET_ONE dir=0 bit=3 delay=0x5A at N -> `set_odelay`=10'h008 at N+1 with `dly_data`=0x5A; readback of out/3 still 0.
- SET_APPLY dir=1 bit=9 delay=0x21, SETTLE_CYCLES=4 -> `set_idelay[9]` at N+1, `ld_idelay`=10'h3FF at N+3, `cmd_ready` at N+8; readback in/9 = 0x21 and out/9 = 0.
- SET_ALL dir=0 delay=0x10, then APPLY dir=0 -> every out-bit readback = 0x10; in-bit readbacks remain 0.
- SET_ONE bit=12 -> `err`=1, no strobes, `cmd_ready` high next cycle; `err_clr` -> `err`=0; simultaneous error and `err_clr` -> `err`=1.
- `rst_n` low while in SETTLE after APPLY -> strobes 0 immediately, `cmd_ready`=1 after release, all readbacks 0.
